// File: rtl/axi4_lite_pkg.sv
// Purpose: shared types and constants for the two-port AXI4-Lite arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: W/R FSM state enums, AW/W/AR payload structs, port index constants.
package axi4_lite_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    W_IDLE,
    W_XFER,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_t;

  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
    logic [2:0]             prot;
  } aw_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0]   data;
    logic [AXIL_DATA_W/8-1:0] strb;
  } w_t;

  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
    logic [2:0]             prot;
  } ar_t;

endpackage

// File: rtl/axi4_lite_arb2_rr.sv
// Purpose: 2-way round-robin picker with optional fixed priority to the DMA port.
// Latency: combinational.
// Backpressure: none; the caller registers the grant.
// Ports: req[1:0] requests, last = previously granted port, fixed_prio forces
//        port 1 on contention; gnt_idx/gnt_vld = chosen port and "someone asked".
module arb2_rr
  import axi4_lite_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic       gnt_idx,
  output logic       gnt_vld
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = PORT_CPU;
    case (req)
      2'b01:   gnt_idx = PORT_CPU;
      2'b10:   gnt_idx = PORT_DMA;
      // Contention: the port that did not win last time goes next.
      2'b11:   gnt_idx = fixed_prio ? PORT_DMA : ~last;
      default: gnt_idx = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/axi4_lite_arb2.sv
// Purpose: arbitrates CPU (port 0) and LPT DMA (port 1) onto one AXI4-Lite port; W and R independent.
// Latency: 1 cycle arbitration, then combinational pass-through of valid/ready/payload.
// Backpressure: grant held from address accept to response handshake; ready/valid pass straight through.
// Ports: clk, resetn (sync, active-low); s0_*/s1_* upstream masters; m_* shared downstream port.
// Option: define AXI4_LITE_ARB2_FIXED_PRIO_EN to make port 1 win every contended grant.
module axi4_lite_arb2
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = AXIL_ADDR_W,
  parameter int DATA_W = AXIL_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  // master 0 (CPU)
  input  logic              s0_awvalid,
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic [2:0]        s0_awprot,
  output logic              s0_awready,
  input  logic              s0_wvalid,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  output logic              s0_wready,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  input  logic              s0_arvalid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [2:0]        s0_arprot,
  output logic              s0_arready,
  output logic              s0_rvalid,
  output logic [DATA_W-1:0] s0_rdata,
  input  logic              s0_rready,
  // master 1 (DMA)
  input  logic              s1_awvalid,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic [2:0]        s1_awprot,
  output logic              s1_awready,
  input  logic              s1_wvalid,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  output logic              s1_wready,
  output logic              s1_bvalid,
  input  logic              s1_bready,
  input  logic              s1_arvalid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [2:0]        s1_arprot,
  output logic              s1_arready,
  output logic              s1_rvalid,
  output logic [DATA_W-1:0] s1_rdata,
  input  logic              s1_rready,
  // shared memory-side port
  output logic              m_awvalid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  input  logic              m_awready,
  output logic              m_wvalid,
  output logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic              m_wready,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              m_rready
);

`ifdef AXI4_LITE_ARB2_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  // Upstream channels gathered into 2-entry vectors indexed by port number.
  aw_t        aw_in [2];
  w_t         w_in  [2];
  ar_t        ar_in [2];
  logic [1:0] awvalid_v, wvalid_v, bready_v, arvalid_v, rready_v;

  assign aw_in[0]  = '{addr: s0_awaddr, prot: s0_awprot};
  assign aw_in[1]  = '{addr: s1_awaddr, prot: s1_awprot};
  assign w_in[0]   = '{data: s0_wdata, strb: s0_wstrb};
  assign w_in[1]   = '{data: s1_wdata, strb: s1_wstrb};
  assign ar_in[0]  = '{addr: s0_araddr, prot: s0_arprot};
  assign ar_in[1]  = '{addr: s1_araddr, prot: s1_arprot};
  assign awvalid_v = {s1_awvalid, s0_awvalid};
  assign wvalid_v  = {s1_wvalid,  s0_wvalid};
  assign bready_v  = {s1_bready,  s0_bready};
  assign arvalid_v = {s1_arvalid, s0_arvalid};
  assign rready_v  = {s1_rready,  s0_rready};

  // ---------------- write channel ----------------
  w_state_t w_state, w_state_nxt;
  logic     gw, gw_nxt, rr_last_w, rr_last_w_nxt;
  logic     aw_done, aw_done_nxt, w_done, w_done_nxt;
  aw_t      aw_q;
  w_t       w_q;
  logic     aw_rdy, w_rdy, b_vld;
  logic     wr_gnt_idx, wr_gnt_vld;

  arb2_rr u_arb_w (
    .req        (awvalid_v | wvalid_v),
    .last       (rr_last_w),
    .fixed_prio (FIXED_PRIO),
    .gnt_idx    (wr_gnt_idx),
    .gnt_vld    (wr_gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state   <= W_IDLE;
      gw        <= PORT_CPU;
      rr_last_w <= PORT_DMA;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      aw_q      <= '0;
      w_q       <= '0;
    end else begin
      w_state   <= w_state_nxt;
      gw        <= gw_nxt;
      rr_last_w <= rr_last_w_nxt;
      aw_done   <= aw_done_nxt;
      w_done    <= w_done_nxt;
      // Payload snapshot so the bus holds its last value outside W_XFER.
      if (w_state == W_XFER) begin
        aw_q <= aw_in[gw];
        w_q  <= w_in[gw];
      end
    end
  end

  always_comb begin
    w_state_nxt   = w_state;
    gw_nxt        = gw;
    rr_last_w_nxt = rr_last_w;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    m_awvalid     = 1'b0;
    m_wvalid      = 1'b0;
    m_bready      = 1'b0;
    aw_rdy        = 1'b0;
    w_rdy         = 1'b0;
    b_vld         = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (wr_gnt_vld) begin
          gw_nxt        = wr_gnt_idx;
          rr_last_w_nxt = wr_gnt_idx;
          w_state_nxt   = W_XFER;
        end
      end
      W_XFER: begin
        // AW and W complete independently; each is masked once it has handshaken.
        m_awvalid = awvalid_v[gw] & ~aw_done;
        aw_rdy    = m_awready & ~aw_done;
        m_wvalid  = wvalid_v[gw] & ~w_done;
        w_rdy     = m_wready & ~w_done;
        if (m_awvalid && m_awready) aw_done_nxt = 1'b1;
        if (m_wvalid && m_wready)   w_done_nxt  = 1'b1;
        if (aw_done_nxt && w_done_nxt) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        b_vld    = m_bvalid;
        m_bready = bready_v[gw];
        if (m_bvalid && bready_v[gw]) begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign s0_awready = aw_rdy & (gw == PORT_CPU);
  assign s1_awready = aw_rdy & (gw == PORT_DMA);
  assign s0_wready  = w_rdy  & (gw == PORT_CPU);
  assign s1_wready  = w_rdy  & (gw == PORT_DMA);
  assign s0_bvalid  = b_vld  & (gw == PORT_CPU);
  assign s1_bvalid  = b_vld  & (gw == PORT_DMA);

  assign m_awaddr = (w_state == W_XFER) ? aw_in[gw].addr : aw_q.addr;
  assign m_awprot = (w_state == W_XFER) ? aw_in[gw].prot : aw_q.prot;
  assign m_wdata  = (w_state == W_XFER) ? w_in[gw].data  : w_q.data;
  assign m_wstrb  = (w_state == W_XFER) ? w_in[gw].strb  : w_q.strb;

  // ---------------- read channel ----------------
  r_state_t r_state, r_state_nxt;
  logic     gr, gr_nxt, rr_last_r, rr_last_r_nxt;
  ar_t      ar_q;
  logic     ar_rdy, r_vld;
  logic     rd_gnt_idx, rd_gnt_vld;

  arb2_rr u_arb_r (
    .req        (arvalid_v),
    .last       (rr_last_r),
    .fixed_prio (FIXED_PRIO),
    .gnt_idx    (rd_gnt_idx),
    .gnt_vld    (rd_gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= R_IDLE;
      gr        <= PORT_CPU;
      rr_last_r <= PORT_DMA;
      ar_q      <= '0;
    end else begin
      r_state   <= r_state_nxt;
      gr        <= gr_nxt;
      rr_last_r <= rr_last_r_nxt;
      if (r_state == R_ADDR) ar_q <= ar_in[gr];
    end
  end

  always_comb begin
    r_state_nxt   = r_state;
    gr_nxt        = gr;
    rr_last_r_nxt = rr_last_r;
    m_arvalid     = 1'b0;
    m_rready      = 1'b0;
    ar_rdy        = 1'b0;
    r_vld         = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (rd_gnt_vld) begin
          gr_nxt        = rd_gnt_idx;
          rr_last_r_nxt = rd_gnt_idx;
          r_state_nxt   = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid = arvalid_v[gr];
        ar_rdy    = m_arready;
        if (arvalid_v[gr] && m_arready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        r_vld    = m_rvalid;
        m_rready = rready_v[gr];
        if (m_rvalid && rready_v[gr]) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign s0_arready = ar_rdy & (gr == PORT_CPU);
  assign s1_arready = ar_rdy & (gr == PORT_DMA);
  assign s0_rvalid  = r_vld  & (gr == PORT_CPU);
  assign s1_rvalid  = r_vld  & (gr == PORT_DMA);
  // Read data fans out to both masters; only rvalid says whose it is.
  assign s0_rdata   = m_rdata;
  assign s1_rdata   = m_rdata;

  assign m_araddr = (r_state == R_ADDR) ? ar_in[gr].addr : ar_q.addr;
  assign m_arprot = (r_state == R_ADDR) ? ar_in[gr].prot : ar_q.prot;

endmodule

// File: tb/tb_axi4_lite_arb2.sv
module tb_axi4_lite_arb2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
  logic [2:0]  s0_awprot, s0_arprot;
  logic [3:0]  s0_wstrb;
  logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
  logic [2:0]  s1_awprot, s1_arprot;
  logic [3:0]  s1_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi4_lite_arb2 dut (
    .clk(clk), .resetn(resetn),
    .s0_awvalid(s0_awvalid), .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot), .s0_awready(s0_awready),
    .s0_wvalid(s0_wvalid), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wready(s0_wready),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arprot(s0_arprot), .s0_arready(s0_arready),
    .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rready(s0_rready),
    .s1_awvalid(s1_awvalid), .s1_awaddr(s1_awaddr), .s1_awprot(s1_awprot), .s1_awready(s1_awready),
    .s1_wvalid(s1_wvalid), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wready(s1_wready),
    .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arprot(s1_arprot), .s1_arready(s1_arready),
    .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rready(s1_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Serve one write whose requester is already asserting aw+w; the next edge is the grant edge.
  task automatic serve_write(input logic exp_port, input logic [31:0] exp_addr);
    cyc();
    m_awready = 1'b1;
    m_wready  = 1'b1;
    settle();
    chk("wr_grant_addr", m_awaddr, exp_addr);
    chk("wr_sel_awready", exp_port ? s1_awready : s0_awready, 1);
    chk("wr_oth_awready", exp_port ? s0_awready : s1_awready, 0);
    cyc();
    if (exp_port) begin s1_awvalid = 0; s1_wvalid = 0; end
    else          begin s0_awvalid = 0; s0_wvalid = 0; end
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b1;
    settle();
    chk("wr_sel_bvalid", exp_port ? s1_bvalid : s0_bvalid, 1);
    chk("wr_oth_bvalid", exp_port ? s0_bvalid : s1_bvalid, 0);
    cyc();
    m_bvalid = 1'b0;
  endtask

  logic first_port;

  initial begin
`ifdef AXI4_LITE_ARB2_FIXED_PRIO_EN
    first_port = 1'b1;
`else
    first_port = 1'b0;
`endif
    resetn = 0;
    {s0_awvalid, s0_wvalid, s0_arvalid, s1_awvalid, s1_wvalid, s1_arvalid} = '0;
    {s0_awaddr, s0_wdata, s0_araddr, s1_awaddr, s1_wdata, s1_araddr} = '0;
    {s0_awprot, s0_arprot, s1_awprot, s1_arprot} = '0;
    s0_wstrb = 0; s1_wstrb = 0;
    s0_bready = 1; s1_bready = 1; s0_rready = 1; s1_rready = 1;
    {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
    m_rdata = 0;
    cyc(); cyc();
    settle();
    // ---- reset state ----
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_awaddr", m_awaddr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_m_rready", m_rready, 0);
    resetn = 1;
    cyc();

    // ---- single CPU write ----
    s0_awvalid = 1; s0_awaddr = 32'h100; s0_wvalid = 1; s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF;
    settle();
    chk("w1_arb_latency", m_awvalid, 0);
    cyc();
    settle();
    chk("w1_m_awvalid", m_awvalid, 1);
    chk("w1_m_awaddr", m_awaddr, 32'h100);
    chk("w1_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("w1_m_wstrb", m_wstrb, 4'hF);
    chk("w1_awready_wait", s0_awready, 0);
    m_awready = 1; m_wready = 1;
    settle();
    chk("w1_s0_awready", s0_awready, 1);
    chk("w1_s0_wready", s0_wready, 1);
    chk("w1_s1_awready", s1_awready, 0);
    cyc();
    s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0;
    settle();
    chk("w1_awvalid_done", m_awvalid, 0);
    chk("w1_awaddr_hold", m_awaddr, 32'h100);
    chk("w1_bvalid_early", s0_bvalid, 0);
    cyc();
    m_bvalid = 1;
    settle();
    chk("w1_s0_bvalid", s0_bvalid, 1);
    chk("w1_s1_bvalid", s1_bvalid, 0);
    chk("w1_m_bready", m_bready, 1);
    cyc();
    m_bvalid = 0;
    settle();
    chk("w1_bvalid_once", s0_bvalid, 0);

    // ---- simultaneous writes after reset ----
    resetn = 0; cyc(); resetn = 1;
    s0_awvalid = 1; s0_wvalid = 1; s0_awaddr = 32'h200;
    s1_awvalid = 1; s1_wvalid = 1; s1_awaddr = 32'h300; s1_wdata = 32'h33; s1_wstrb = 4'hF;
    serve_write(first_port, first_port ? 32'h300 : 32'h200);
    serve_write(~first_port, first_port ? 32'h200 : 32'h300);
    // lone s0 write leaves port 0 as last winner, so contention now goes to s1 either way
    s0_awvalid = 1; s0_wvalid = 1; s0_awaddr = 32'h210;
    serve_write(1'b0, 32'h210);
    s0_awvalid = 1; s0_wvalid = 1; s0_awaddr = 32'h220;
    s1_awvalid = 1; s1_wvalid = 1; s1_awaddr = 32'h320;
    serve_write(1'b1, 32'h320);
    serve_write(1'b0, 32'h220);

    // ---- W before AW on s1, s0 waiting ----
    s1_wvalid = 1; s1_wdata = 32'hCAFEF00D; s1_wstrb = 4'h3;
    s0_awvalid = 1; s0_wvalid = 1; s0_awaddr = 32'h380; s0_wdata = 32'h11112222; s0_wstrb = 4'hF;
    m_awready = 1; m_wready = 1;
    cyc();
    settle();
    chk("wa_m_wvalid", m_wvalid, 1);
    chk("wa_m_awvalid", m_awvalid, 0);
    chk("wa_m_wdata", m_wdata, 32'hCAFEF00D);
    chk("wa_m_wstrb", m_wstrb, 4'h3);
    chk("wa_s1_wready", s1_wready, 1);
    chk("wa_s0_awready", s0_awready, 0);
    cyc();
    s1_wvalid = 0;
    settle();
    chk("wa_wvalid_done", m_wvalid, 0);
    chk("wa_wready_done", s1_wready, 0);
    cyc();
    s1_awvalid = 1; s1_awaddr = 32'h340;
    settle();
    chk("wa_m_awvalid_late", m_awvalid, 1);
    chk("wa_m_awaddr", m_awaddr, 32'h340);
    chk("wa_wdata_hold", m_wdata, 32'hCAFEF00D);
    cyc();
    s1_awvalid = 0; m_bvalid = 1; s1_bready = 0;
    settle();
    chk("wa_s1_bvalid", s1_bvalid, 1);
    chk("wa_m_bready_low", m_bready, 0);
    chk("wa_no_regrant", m_awvalid, 0);
    cyc();
    settle();
    chk("wa_bvalid_held", s1_bvalid, 1);
    chk("wa_s0_blocked", s0_awready, 0);
    s1_bready = 1;
    settle();
    chk("wa_m_bready", m_bready, 1);
    cyc();
    m_bvalid = 0;
    serve_write(1'b0, 32'h380);

    // ---- concurrent read (s1) and write (s0) ----
    s1_arvalid = 1; s1_araddr = 32'h400;
    s0_awvalid = 1; s0_wvalid = 1; s0_awaddr = 32'h500; s0_wdata = 32'h55;
    cyc();
    m_arready = 1; m_awready = 1; m_wready = 1;
    settle();
    chk("cc_m_arvalid", m_arvalid, 1);
    chk("cc_m_araddr", m_araddr, 32'h400);
    chk("cc_s1_arready", s1_arready, 1);
    chk("cc_s0_arready", s0_arready, 0);
    chk("cc_m_awaddr", m_awaddr, 32'h500);
    chk("cc_s0_awready", s0_awready, 1);
    cyc();
    s1_arvalid = 0; s0_awvalid = 0; s0_wvalid = 0;
    m_arready = 0; m_awready = 0; m_wready = 0;
    m_rvalid = 1; m_rdata = 32'h12345678; m_bvalid = 1;
    settle();
    chk("cc_s1_rvalid", s1_rvalid, 1);
    chk("cc_s1_rdata", s1_rdata, 32'h12345678);
    chk("cc_s0_rvalid", s0_rvalid, 0);
    chk("cc_m_rready", m_rready, 1);
    chk("cc_s0_bvalid", s0_bvalid, 1);
    cyc();
    m_rvalid = 0; m_bvalid = 0;

    // ---- read backpressure ----
    m_arready = 1;
    s0_arvalid = 1; s0_araddr = 32'h600;
    cyc();
    settle();
    chk("bp_m_araddr", m_araddr, 32'h600);
    chk("bp_s0_arready", s0_arready, 1);
    s1_arvalid = 1; s1_araddr = 32'h700;
    cyc();
    s0_arvalid = 0; m_rvalid = 1; m_rdata = 32'hA5A5A5A5; s0_rready = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_m_rready", m_rready, 0);
      chk("bp_s0_rvalid", s0_rvalid, 1);
      chk("bp_s1_arready", s1_arready, 0);
      cyc();
    end
    s0_rready = 1;
    settle();
    chk("bp_m_rready_hs", m_rready, 1);
    cyc();
    m_rvalid = 0;
    settle();
    chk("bp_arb_latency", m_arvalid, 0);
    chk("bp_araddr_hold", m_araddr, 32'h600);
    cyc();
    settle();
    chk("bp_s1_m_araddr", m_araddr, 32'h700);
    chk("bp_s1_arready_g", s1_arready, 1);
    cyc();
    s1_arvalid = 0; m_rvalid = 1;
    cyc();
    m_rvalid = 0; m_arready = 0;

    // ---- reset mid-write, then lone s1 request ----
    s0_awvalid = 1; s0_wvalid = 1; s0_awaddr = 32'h800; s0_wdata = 32'h8888;
    m_awready = 1; m_wready = 0;
    cyc();
    settle();
    chk("rx_m_awvalid", m_awvalid, 1);
    cyc();
    settle();
    chk("rx_aw_done", m_awvalid, 0);
    chk("rx_w_pending", m_wvalid, 1);
    resetn = 0; s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_bvalid = 1;
    cyc();
    settle();
    chk("rx_m_wvalid", m_wvalid, 0);
    chk("rx_m_awaddr", m_awaddr, 0);
    chk("rx_m_wdata", m_wdata, 0);
    chk("rx_s0_bvalid", s0_bvalid, 0);
    chk("rx_m_bready", m_bready, 0);
    chk("rx_s0_wready", s0_wready, 0);
    resetn = 1; m_bvalid = 0;
    s1_awvalid = 1; s1_wvalid = 1; s1_awaddr = 32'h900;
    serve_write(1'b1, 32'h900);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
